// File: rtl/simt_div_ctrl.sv
// Per-warp SIMT divergence controller: owns warp PC/mask and drives
// push/pop of the reconvergence stack on divergent branches and sync hits.
module simt_div_ctrl #(
  parameter int          THREADS     = 4,
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int          STK_ENTRIES = 16
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               adv,
  input  logic               halt,
  input  logic               br_valid,
  input  logic [THREADS-1:0] br_taken,
  input  logic [31:0]        br_target,
  input  logic [31:0]        br_sync,
  input  logic [THREADS-1:0] top_mask,
  input  logic [31:0]        top_sync,
  input  logic [31:0]        top_addr,
  output logic [31:0]        fetch_pc,
  output logic [THREADS-1:0] fetch_mask,
  output logic               fetch_valid,
  output logic               redirect,
  output logic               push_en,
  output logic               pop_en,
  output logic [THREADS-1:0] new_mask,
  output logic [31:0]        new_sync,
  output logic [31:0]        new_addr,
  output logic [3:0]         depth,
  output logic               fault
);

  typedef enum logic [2:0] {
    S_RUN,
    S_PUSH,
    S_PUSH_LD,
    S_POP,
    S_POP_LD,
    S_HALTED,
    S_FAULT
  } state_t;

  // A push adds a pair; beyond this depth the pair would not fit.
  localparam logic [3:0] DEPTH_MAX = 4'(STK_ENTRIES - 3);

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [THREADS-1:0] mask_q, mask_d;
  logic [3:0]         depth_q, depth_d;
  logic [THREADS-1:0] nmask_q, nmask_d;
  logic [31:0]        nsync_q, nsync_d;
  logic [31:0]        naddr_q, naddr_d;
  logic               redir_q, redir_d;

  logic [THREADS-1:0] taken_act;
  logic               sync_hit;
  logic               live;

  assign taken_act = br_taken & mask_q;
  assign sync_hit  = (pc_q == top_sync) && (depth_q != 4'd0);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
      mask_q  <= '1;
      depth_q <= 4'd0;
      nmask_q <= '0;
      nsync_q <= 32'd0;
      naddr_q <= 32'd0;
      redir_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mask_q  <= mask_d;
      depth_q <= depth_d;
      nmask_q <= nmask_d;
      nsync_q <= nsync_d;
      naddr_q <= naddr_d;
      redir_q <= redir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mask_d  = mask_q;
    depth_d = depth_q;
    nmask_d = nmask_q;
    nsync_d = nsync_q;
    naddr_d = naddr_q;
    redir_d = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (halt) begin
          state_d = S_HALTED;
        end else if (br_valid && (taken_act == mask_q)) begin
          pc_d    = br_target;
          redir_d = 1'b1;
        end else if (br_valid && (taken_act == '0)) begin
          state_d = S_RUN;
        end else if (br_valid) begin
          if (depth_q > DEPTH_MAX) begin
            state_d = S_FAULT;
          end else begin
            nmask_d = mask_q & ~taken_act;
            nsync_d = br_sync;
            naddr_d = br_target;
            state_d = S_PUSH;
          end
        end else if (sync_hit) begin
          state_d = S_POP;
        end else if (adv) begin
          pc_d = pc_q + 32'd4;
        end
      end
      S_PUSH: begin
        depth_d = depth_q + 4'd2;
        state_d = br_valid ? S_FAULT : S_PUSH_LD;
      end
      S_POP: begin
        depth_d = depth_q - 4'd1;
        state_d = br_valid ? S_FAULT : S_POP_LD;
      end
      S_PUSH_LD, S_POP_LD: begin
        if (br_valid) begin
          state_d = S_FAULT;
        end else begin
          pc_d    = top_addr;
          mask_d  = top_mask;
          redir_d = 1'b1;
          state_d = S_RUN;
        end
      end
      S_HALTED: state_d = S_HALTED;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_FAULT;
    endcase
  end

  assign live = (state_q != S_HALTED) && (state_q != S_FAULT);

  assign fetch_pc    = pc_q;
  assign fetch_mask  = mask_q;
  assign depth       = depth_q;
  assign fetch_valid = (state_q == S_RUN) && !sync_hit && !halt;
  assign redirect    = redir_q && live;
  assign push_en     = (state_q == S_PUSH);
  assign pop_en      = (state_q == S_POP);
  assign new_mask    = live ? nmask_q : '0;
  assign new_sync    = live ? nsync_q : 32'd0;
  assign new_addr    = live ? naddr_q : 32'd0;
  assign fault       = (state_q == S_FAULT);

endmodule
